// File: rtl/mist1032isa_fifo_word_unpacker.sv
// mist1032isa_fifo_word_unpacker: splits two-word FIFO entries into single words for a valid/busy consumer.
// The next entry is popped in the same cycle the last half of the current one is accepted.
module mist1032isa_fifo_word_unpacker #(
  parameter int N = 32,
  parameter int CNT_N = 16
) (
  input  logic             iCLOCK,
  input  logic             iRESET,
  input  logic             iFLUSH,
  input  logic             iFIFO_EMPTY,
  input  logic [2*N:0]     iFIFO_DATA,
  output logic             oFIFO_RD_EN,
  output logic             oOUT_VALID,
  output logic [N-1:0]     oOUT_DATA,
  input  logic             iOUT_BUSY,
  output logic             oIDLE,
  output logic [CNT_N-1:0] oWORD_COUNT
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;
  state_t state_q, state_d;
  logic [2*N-1:0] buf_q, buf_d;
  logic low_only_q, low_only_d;
  logic [CNT_N-1:0] cnt_q, cnt_d;
  logic xfer, drained, reload;
  // drained: nothing left to show after this cycle, so a waiting entry may load now
  always_comb begin
    xfer = (state_q != IDLE) && !iOUT_BUSY;
    drained = (state_q == IDLE) || (xfer && ((state_q == HIGH) || low_only_q));
    reload = drained && !iFIFO_EMPTY && !iFLUSH && !iRESET;
    state_d = iFLUSH ? IDLE : reload ? LOW : drained ? IDLE : xfer ? HIGH : state_q;
    buf_d = iFLUSH ? '0 : reload ? iFIFO_DATA[2*N-1:0] : buf_q;
    low_only_d = iFLUSH ? 1'b0 : reload ? iFIFO_DATA[2*N] : low_only_q;
    cnt_d = iFLUSH ? '0 : cnt_q + CNT_N'(xfer);
  end
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      state_q <= IDLE;
      buf_q <= '0;
      low_only_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      buf_q <= buf_d;
      low_only_q <= low_only_d;
      cnt_q <= cnt_d;
    end
  end
  assign oFIFO_RD_EN = reload;
  assign oOUT_VALID = state_q != IDLE;
  assign oIDLE = state_q == IDLE;
  assign oOUT_DATA = (state_q == LOW) ? buf_q[N-1:0] : (state_q == HIGH) ? buf_q[2*N-1:N] : '0;
  assign oWORD_COUNT = cnt_q;
endmodule
